// File: rtl/bus_master_if_if.sv
// Shared-bus signal bundle between one bus master sequencer and the
// arbiter / slave multiplexer side. Request, strobe and ready are active low.
interface bus_master_if_if #(
    parameter int ADDR_W = 30,
    parameter int DATA_W = 32
);
    logic              bus_req_;
    logic              bus_grnt_;
    logic              bus_as_;
    logic              bus_rw;
    logic [ADDR_W-1:0] bus_addr;
    logic [DATA_W-1:0] bus_wr_data;
    logic [DATA_W-1:0] bus_rd_data;
    logic              bus_rdy_;

    modport master (
        output bus_req_, bus_as_, bus_rw, bus_addr, bus_wr_data,
        input  bus_grnt_, bus_rd_data, bus_rdy_
    );

    modport slave (
        input  bus_req_, bus_as_, bus_rw, bus_addr, bus_wr_data,
        output bus_grnt_, bus_rd_data, bus_rdy_
    );
endinterface

// File: rtl/bus_master_if.sv
// Turns one requester access into a full shared-bus transaction:
// request/grant, single address strobe, ready wait with timeout, release.
module bus_master_if #(
    parameter int ADDR_W  = 30,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              access_req,
    input  logic              access_rw,
    input  logic [ADDR_W-1:0] access_addr,
    input  logic [DATA_W-1:0] access_wr_data,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [DATA_W-1:0] rd_data,
    bus_master_if_if.master   bus
);
    // Counter only needs to reach TIMEOUT-1 (first WAIT cycle counts as 0).
    localparam int               CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {IDLE, REQ, ACCESS, WAIT, DONE} state_t;

    typedef struct packed {
        logic              rw;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wr_data;
    } access_t;

    state_t           state, state_d;
    access_t          acc;
    logic [CNT_W-1:0] wait_cnt;
    logic             err_flag;
    logic             wait_hit;
    logic             wait_expired;

    // Ready wins over timeout when both land in the same WAIT cycle.
    assign wait_hit     = (state == WAIT) && !bus.bus_rdy_;
    assign wait_expired = (state == WAIT) && bus.bus_rdy_ && (wait_cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            acc      <= '0;
            wait_cnt <= '0;
            err_flag <= 1'b0;
            rd_data  <= '0;
        end else begin
            state <= state_d;
            if (state == IDLE && access_req)
                acc <= '{rw: access_rw, addr: access_addr, wr_data: access_wr_data};
            if (state == ACCESS)
                wait_cnt <= '0;
            else if (state == WAIT)
                wait_cnt <= wait_cnt + CNT_W'(1);
            if (wait_hit) begin
                if (acc.rw)
                    rd_data <= bus.bus_rd_data;
                err_flag <= 1'b0;
            end else if (wait_expired) begin
                rd_data  <= '0;
                err_flag <= 1'b1;
            end
        end
    end

    // Bus fields are zero outside ACCESS/WAIT so an idle master adds nothing to the mux.
    always_comb begin
        state_d         = state;
        busy            = 1'b0;
        done            = 1'b0;
        err             = 1'b0;
        bus.bus_req_    = 1'b1;
        bus.bus_as_     = 1'b1;
        bus.bus_rw      = 1'b1;
        bus.bus_addr    = '0;
        bus.bus_wr_data = '0;
        unique case (state)
            IDLE: begin
                busy = access_req;
                if (access_req)
                    state_d = REQ;
            end
            REQ: begin
                busy         = 1'b1;
                bus.bus_req_ = 1'b0;
                if (!bus.bus_grnt_)
                    state_d = ACCESS;
            end
            ACCESS: begin
                busy            = 1'b1;
                bus.bus_req_    = 1'b0;
                bus.bus_as_     = 1'b0;
                bus.bus_rw      = acc.rw;
                bus.bus_addr    = acc.addr;
                bus.bus_wr_data = acc.wr_data;
                state_d         = WAIT;
            end
            WAIT: begin
                busy            = 1'b1;
                bus.bus_req_    = 1'b0;
                bus.bus_rw      = acc.rw;
                bus.bus_addr    = acc.addr;
                bus.bus_wr_data = acc.wr_data;
                if (wait_hit || wait_expired)
                    state_d = DONE;
            end
            DONE: begin
                done    = 1'b1;
                err     = err_flag;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_bus_master_if.sv
// Bench for bus_master_if: table of transactions with arbiter/slave emulation,
// scoreboard of completion results, plus hand-written reset/back-to-back/glitch sequences.
module tb_bus_master_if;
    localparam int ADDR_W  = 30;
    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              access_req;
    logic              access_rw;
    logic [ADDR_W-1:0] access_addr;
    logic [DATA_W-1:0] access_wr_data;
    logic              busy;
    logic              done;
    logic              err;
    logic [DATA_W-1:0] rd_data;

    bus_master_if_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    bus_master_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
        .clk            (clk),
        .reset          (reset),
        .access_req     (access_req),
        .access_rw      (access_rw),
        .access_addr    (access_addr),
        .access_wr_data (access_wr_data),
        .busy           (busy),
        .done           (done),
        .err            (err),
        .rd_data        (rd_data),
        .bus            (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic              rw;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        int                gd;     // REQ cycles before grant goes low
        int                rdl;    // WAIT cycles before rdy_ goes low (255 = never)
        logic [DATA_W-1:0] sdata;
        int                lat;    // accept cycle to done cycle
        logic              exp_err;
        logic [DATA_W-1:0] exp_rd;
    } vec_t;

    typedef struct packed {
        logic [DATA_W-1:0] rd;
        logic              err;
    } exp_t;

    vec_t vecs[6];
    exp_t sb_q[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    // Scoreboard: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done: got done=1, want no completion");
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("sb_rd_data", rd_data, e.rd);
                chk("sb_err", err, e.err);
            end
        end
    end

    task automatic run_access(input vec_t v);
        int c, as_cyc, as_cnt, req_cnt;
        bit got;
        as_cyc = -1; as_cnt = 0; req_cnt = 0; got = 0; c = 0;
        @(negedge clk);
        access_req = 1'b1; access_rw = v.rw; access_addr = v.addr; access_wr_data = v.wdata;
        bus.bus_grnt_ = 1'b1; bus.bus_rdy_ = 1'b1;
        #1;
        chk("accept_busy", busy, 1);
        chk("accept_req_", bus.bus_req_, 1);
        sb_q.push_back('{rd: v.exp_rd, err: v.exp_err});
        while (!got && c < 300) begin
            @(negedge clk);
            c++;
            access_req = 1'b0;
            if (done) begin
                got = 1;
                chk("latency", c, v.lat);
                chk("done_req_", bus.bus_req_, 1);
                chk("done_addr", bus.bus_addr, 0);
                chk("done_rw", bus.bus_rw, 1);
                chk("done_busy", busy, 0);
            end else begin
                if (!bus.bus_req_) req_cnt++;
                if (!bus.bus_as_) begin as_cnt++; as_cyc = c; end
                if (as_cyc >= 0) begin
                    chk("bus_addr", bus.bus_addr, v.addr);
                    chk("bus_wr_data", bus.bus_wr_data, v.wdata);
                    chk("bus_rw", bus.bus_rw, v.rw);
                end
                bus.bus_grnt_   = (c >= 1 + v.gd) ? 1'b0 : 1'b1;
                bus.bus_rdy_    = 1'b1;
                bus.bus_rd_data = 32'hBAD0_BAD0;
                if (as_cyc >= 0 && c > as_cyc && (c - as_cyc - 1) == v.rdl) begin
                    bus.bus_rdy_    = 1'b0;
                    bus.bus_rd_data = v.sdata;
                end
            end
        end
        if (!got) chk("done_seen", 0, 1);
        chk("as_cycles", as_cnt, 1);
        chk("req_cycles", req_cnt, v.lat - 1);
        bus.bus_grnt_ = 1'b1;
        bus.bus_rdy_  = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{1'b1, 30'h40,        32'h0,         0, 0,   32'hDEADBEEF, 4, 1'b0, 32'hDEADBEEF};
        vecs[1] = '{1'b0, 30'h100,       32'h12345678,  3, 2,   32'h0,        9, 1'b0, 32'hDEADBEEF};
        vecs[2] = '{1'b1, 30'h200,       32'h0,         0, 255, 32'hCAFEF00D, 7, 1'b1, 32'h0};
        vecs[3] = '{1'b1, 30'h2AAAAAAA,  32'h0,         1, 3,   32'hA5A50F0F, 8, 1'b0, 32'hA5A50F0F};
        vecs[4] = '{1'b0, 30'h15555555,  32'h0F0FF0F0,  0, 0,   32'h0,        4, 1'b0, 32'hA5A50F0F};
        vecs[5] = '{1'b1, 30'h3FFFFFFF,  32'h0,         2, 1,   32'hFFFFFFFF, 7, 1'b0, 32'hFFFFFFFF};

        reset = 1'b1; access_req = 1'b0; access_rw = 1'b0; access_addr = '0; access_wr_data = '0;
        bus.bus_grnt_ = 1'b1; bus.bus_rdy_ = 1'b1; bus.bus_rd_data = '0;
        repeat (2) @(negedge clk);
        chk("rst_req_", bus.bus_req_, 1);
        chk("rst_as_", bus.bus_as_, 1);
        chk("rst_rw", bus.bus_rw, 1);
        chk("rst_addr", bus.bus_addr, 0);
        chk("rst_wdata", bus.bus_wr_data, 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        access_req = 1'b1;
        #1 chk("rst_busy_follows_req", busy, 1);
        @(negedge clk);
        access_req = 1'b0;
        reset = 1'b0;
        #1 chk("rst_busy_low", busy, 0);

        for (int i = 0; i < 5; i++) run_access(vecs[i]);

        // Back-to-back: access_req held high, grant and ready immediate.
        sb_q.push_back('{rd: 32'h11112222, err: 1'b0});
        sb_q.push_back('{rd: 32'h33334444, err: 1'b0});
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            access_req = (c < 9); access_rw = 1'b1; access_addr = 30'h77;
            bus.bus_grnt_ = 1'b0; bus.bus_rdy_ = 1'b0;
            bus.bus_rd_data = (c < 5) ? 32'h11112222 : 32'h33334444;
            #1;
            chk("b2b_busy", busy, !(c == 4 || c == 9));
            chk("b2b_done", done, (c == 4 || c == 9));
        end
        bus.bus_grnt_ = 1'b1; bus.bus_rdy_ = 1'b1; access_req = 1'b0;

        // Grant/ready glitches while idle must not start anything.
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            bus.bus_grnt_ = c[0]; bus.bus_rdy_ = ~c[0];
            #1;
            chk("glitch_req_", bus.bus_req_, 1);
            chk("glitch_as_", bus.bus_as_, 1);
            chk("glitch_busy", busy, 0);
            chk("glitch_done", done, 0);
        end
        bus.bus_grnt_ = 1'b1; bus.bus_rdy_ = 1'b1;
        run_access(vecs[0]);

        // Reset while in WAIT: dropped access, no done, bus released.
        @(negedge clk);
        access_req = 1'b1; access_rw = 1'b1; access_addr = 30'h55; bus.bus_grnt_ = 1'b0;
        @(negedge clk);
        access_req = 1'b0;
        chk("mid_req_c1", bus.bus_req_, 0);
        @(negedge clk);
        chk("mid_as_c2", bus.bus_as_, 0);
        @(negedge clk);
        chk("mid_wait_as_", bus.bus_as_, 1);
        chk("mid_wait_req_", bus.bus_req_, 0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        bus.bus_grnt_ = 1'b1;
        #1;
        chk("mid_rst_req_", bus.bus_req_, 1);
        chk("mid_rst_as_", bus.bus_as_, 1);
        chk("mid_rst_addr", bus.bus_addr, 0);
        chk("mid_rst_rw", bus.bus_rw, 1);
        chk("mid_rst_rd_data", rd_data, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_busy", busy, 0);
        @(negedge clk);
        chk("mid_after_done", done, 0);
        chk("mid_after_req_", bus.bus_req_, 1);
        run_access(vecs[5]);

        repeat (2) @(negedge clk);
        chk("sb_drained", sb_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/bus_master_if.md
# bus_master_if

Single-master bus interface sequencer that turns one pipeline memory access into a complete transaction on the shared 4-master bus. It requests bus ownership from the round-robin bus arbiter and waits for the grant. It then drives one address strobe, waits for the slave's ready, returns read data to the requester and releases the bus. One instance sits between each bus master (instruction fetch, data access) and the bus arbiter / slave multiplexer.

## Interface
Parameters:
- ADDR_W, 30, word address width
- DATA_W, 32, data width
- TIMEOUT, 255, maximum WAIT cycles before abort (≥1)

Ports (bus-side suffix `_` = active-low):
- clk  in  1  single clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- access_req  in  1  start access; sampled only in IDLE
- access_rw  in  1  1 = read, 0 = write
- access_addr  in  ADDR_W  access address
- access_wr_data  in  DATA_W  write data
- busy  out  1  stall the requester (combinational)
- done  out  1  one-cycle completion pulse
- err  out  1  completion was a timeout abort; valid with done
- rd_data  out  DATA_W  read result; valid from done, held until next completion
- bus_req_  out  1  bus request to arbiter
- bus_grnt_  in  1  grant from arbiter
- bus_as_  out  1  address strobe
- bus_rw  out  1  1 = read, 0 = write
- bus_addr  out  ADDR_W  bus address
- bus_wr_data  out  DATA_W  bus write data
- bus_rd_data  in  DATA_W  slave read data
- bus_rdy_  in  1  slave ready

## Operation
- States: IDLE, REQ, ACCESS, WAIT, DONE. Registered 5-state FSM; ~8-bit WAIT counter sized for TIMEOUT.
- IDLE: if access_req=1, latch rw/addr/wr_data and go to REQ. Otherwise stay.
- REQ: bus_req_=0. If bus_grnt_=0 go to ACCESS. No timeout.
- ACCESS: bus_req_=0, bus_as_=0, latched rw/addr/wr_data driven on bus. Always go to WAIT after one cycle. Clear the WAIT counter.
- WAIT: bus_req_=0, bus_as_=1, bus fields still driven. Counter increments each cycle.
  - If bus_rdy_=0: capture bus_rd_data into rd_data (reads only; writes leave rd_data unchanged), clear err flag, go to DONE.
  - Otherwise, if counter = TIMEOUT−1: rd_data←0, set err flag, go to DONE.
- DONE: bus_req_=1, done=1, err=flag. Always go to IDLE.
- bus_grnt_ is ignored outside REQ; bus_rdy_ is ignored outside WAIT.
- Outside ACCESS/WAIT: bus_addr=0, bus_wr_data=0, bus_rw=1. Inactive masters contribute zero to the bus mux.
- busy = (IDLE & access_req) | REQ | ACCESS | WAIT. busy is low in DONE.
- If access_req is still high in DONE, it is taken as a new access in the following IDLE cycle.

## Timing
- Reset (synchronous): state=IDLE, bus_req_=1, bus_as_=1, bus_rw=1, bus_addr=0, bus_wr_data=0, rd_data=0, done=0, err=0. busy = access_req.
- Reset mid-transaction: the FSM is in IDLE after the edge and the bus is released next cycle. No done pulse; the in-flight access is dropped.
- Minimum latency, with the grant already low in REQ and rdy_ low in the first WAIT cycle:
  - c0 IDLE accept, c1 REQ, c2 ACCESS (as_ low), c3 WAIT (rdy_ sampled), c4 DONE (done=1).
  - Accept to done is therefore 4 cycles.
- Each extra grant-wait cycle or rdy_-wait cycle adds 1 cycle.
- bus_as_ is low for exactly one cycle per transaction.
- bus_req_ is held low continuously from REQ through WAIT. This keeps ownership under the arbiter's hold-while-requesting rule.
- Timeout: no rdy_ in TIMEOUT WAIT cycles → DONE on the cycle after the TIMEOUT-th WAIT cycle, with err=1.

## Test plan
- Read, grant immediate, rdy_ in first WAIT cycle, bus_rd_data=32'hDEADBEEF:
  - done at c4, rd_data=32'hDEADBEEF, err=0.
  - bus_as_ low only in c2; bus_req_ low c1–c3.
- Write addr=30'h100, data=32'h12345678, grant delayed 3 cycles, rdy_ after 2 WAIT cycles:
  - bus_addr/bus_wr_data/bus_rw=0 stable through ACCESS+WAIT.
  - done at c9; rd_data unchanged.
- Read with TIMEOUT=4 and rdy_ never asserted:
  - done after 4 WAIT cycles, err=1, rd_data=0, bus_req_ released in DONE.
- Reset asserted in WAIT:
  - next cycle all outputs at reset values, no done pulse.
  - A subsequent read completes normally.
- access_req held high across two accesses: back-to-back transactions.
  - Second accept in the IDLE cycle after DONE.
  - busy low only in each DONE cycle.
- Glitches on bus_grnt_ and bus_rdy_ while in IDLE have no effect: state stays IDLE, bus_req_ stays 1.
